// File: rtl/bcd_converter_seq.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_converter_seq
//  Description : Sequential binary-to-BCD converter using the double-dabble
//                algorithm. One shift-and-add-3 step per clock cycle, so a
//                conversion takes WIDTH cycles. Conversions can be started
//                with a start pulse, or launched automatically whenever the
//                binary input changes. The result register only updates
//                when a conversion completes, so a display never shows a
//                partial value.
//  Revision    : 1.0 - initial release
// ============================================================================
module bcd_converter_seq #(
  parameter int WIDTH  = 32,
  parameter int DIGITS = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start_i,
  input  logic                  auto_en_i,
  input  logic [WIDTH-1:0]      bin_i,
  output logic [4*DIGITS-1:0]   bcd_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  valid_o
);

  localparam int c_CNT_W = $clog2(WIDTH + 1);
  localparam int c_BCD_W = 4 * DIGITS;

  localparam logic [0:0] c_ST_IDLE = 1'b0;
  localparam logic [0:0] c_ST_CONV = 1'b1;

  // Counter value on the last double-dabble step of a conversion.
  localparam logic [c_CNT_W-1:0] c_LAST_STEP = c_CNT_W'(WIDTH - 1);

  logic [0:0]         state_q,    state_d;
  logic [WIDTH-1:0]   shift_q,    shift_d;
  logic [c_BCD_W-1:0] scratch_q,  scratch_d;
  logic [WIDTH-1:0]   last_bin_q, last_bin_d;
  logic [c_CNT_W-1:0] cnt_q,      cnt_d;
  logic [c_BCD_W-1:0] bcd_q,      bcd_d;
  logic               done_q,     done_d;
  logic               valid_q,    valid_d;

  logic               w_launch;
  logic               w_last_step;
  logic [c_BCD_W-1:0] w_adj;
  logic [c_BCD_W-1:0] w_step;

  // A start request and an auto-trigger in the same cycle collapse into one launch.
  assign w_launch    = start_i | (auto_en_i & (bin_i != last_bin_q));
  assign w_last_step = (cnt_q == c_LAST_STEP);

  // Add-3 correction: any digit >= 5 would become >= 10 after the shift.
  for (genvar d = 0; d < DIGITS; d++) begin : g_digit_adj
    assign w_adj[4*d +: 4] = (scratch_q[4*d +: 4] >= 4'd5) ?
                             (scratch_q[4*d +: 4] + 4'd3) :
                              scratch_q[4*d +: 4];
  end

  // Shift the corrected scratch left, feeding in the binary MSB.
  assign w_step = {w_adj[c_BCD_W-2:0], shift_q[WIDTH-1]};

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= c_ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: launch from IDLE, return after the final step.
  always_comb begin
    state_d = state_q;
    case (state_q)
      c_ST_IDLE: if (w_launch)    state_d = c_ST_CONV;
      c_ST_CONV: if (w_last_step) state_d = c_ST_IDLE;
      default:                    state_d = c_ST_IDLE;
    endcase
  end

  // Datapath/output next values: capture on launch, one dabble step per CONV cycle.
  always_comb begin
    shift_d    = shift_q;
    scratch_d  = scratch_q;
    last_bin_d = last_bin_q;
    cnt_d      = cnt_q;
    bcd_d      = bcd_q;
    done_d     = 1'b0;
    valid_d    = valid_q;
    case (state_q)
      c_ST_IDLE: begin
        if (w_launch) begin
          shift_d    = bin_i;
          last_bin_d = bin_i;
          scratch_d  = '0;
          cnt_d      = '0;
        end
      end
      c_ST_CONV: begin
        shift_d   = shift_q << 1;
        scratch_d = w_step;
        if (w_last_step) begin
          // Hold the counter at its final value rather than wrapping.
          bcd_d   = w_step;
          done_d  = 1'b1;
          valid_d = 1'b1;
        end else begin
          cnt_d = cnt_q + c_CNT_W'(1);
        end
      end
      default: begin
        done_d = 1'b0;
      end
    endcase
  end

  // Datapath registers, all cleared asynchronously so a reset aborts a conversion.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_q    <= '0;
      scratch_q  <= '0;
      last_bin_q <= '0;
      cnt_q      <= '0;
      bcd_q      <= '0;
      done_q     <= 1'b0;
      valid_q    <= 1'b0;
    end else begin
      shift_q    <= shift_d;
      scratch_q  <= scratch_d;
      last_bin_q <= last_bin_d;
      cnt_q      <= cnt_d;
      bcd_q      <= bcd_d;
      done_q     <= done_d;
      valid_q    <= valid_d;
    end
  end

  assign bcd_o   = bcd_q;
  assign busy_o  = (state_q == c_ST_CONV);
  assign done_o  = done_q;
  assign valid_o = valid_q;

endmodule
`default_nettype wire

// File: tb/tb_bcd_converter_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bcd_converter_seq
//  Description : Self-checking bench for bcd_converter_seq. Directed steps for
//                reset, latency, ignored requests, auto mode and back-to-back
//                conversions, followed by a random regression against a
//                decimal-arithmetic reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_bcd_converter_seq;

  localparam int WIDTH  = 32;
  localparam int DIGITS = 10;
  localparam int c_NRAND = 1200;

  logic                clk;
  logic                rst_n;
  logic                start;
  logic                auto_en;
  logic [WIDTH-1:0]    bin;
  logic [4*DIGITS-1:0] bcd_o;
  logic                busy_o;
  logic                done_o;
  logic                valid_o;

  int checks = 0;
  int errors = 0;

  bcd_converter_seq #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start_i   (start),
    .auto_en_i (auto_en),
    .bin_i     (bin),
    .bcd_o     (bcd_o),
    .busy_o    (busy_o),
    .done_o    (done_o),
    .valid_o   (valid_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: decimal digits by repeated division.
  function automatic logic [4*DIGITS-1:0] ref_bcd(input longint unsigned v);
    logic [4*DIGITS-1:0] r;
    r = '0;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  function automatic bit digits_ok(input logic [4*DIGITS-1:0] b);
    for (int i = 0; i < DIGITS; i++)
      if (b[4*i +: 4] > 4'd9) return 1'b0;
    return 1'b1;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Called at the first negedge where busy should be high. Follows the
  // conversion to its done cycle and checks everything, then advances one
  // more negedge to confirm done is a single pulse.
  task automatic measure(input string tag, input logic [WIDTH-1:0] v,
                         input int chg_at, input logic [WIDTH-1:0] chg_val,
                         input int stop_start_at);
    int n;
    logic [4*DIGITS-1:0] held;
    bit hold_ok, nodone_ok;
    held = bcd_o; hold_ok = 1'b1; nodone_ok = 1'b1; n = 0;
    while (busy_o === 1'b1 && n < 100) begin
      if (bcd_o !== held)   hold_ok   = 1'b0;
      if (done_o !== 1'b0)  nodone_ok = 1'b0;
      if (n == chg_at)        bin   = chg_val;
      if (n == stop_start_at) start = 1'b0;
      n++;
      @(negedge clk);
    end
    check({tag, "_busy_width"}, 64'(n), 64'(WIDTH));
    check({tag, "_bcd_held"}, {63'd0, hold_ok}, 64'd1);
    check({tag, "_no_early_done"}, {63'd0, nodone_ok}, 64'd1);
    check({tag, "_done"}, {63'd0, done_o}, 64'd1);
    check({tag, "_bcd"}, 64'(bcd_o), 64'(ref_bcd(64'(v))));
    check({tag, "_digits"}, {63'd0, digits_ok(bcd_o)}, 64'd1);
    check({tag, "_valid"}, {63'd0, valid_o}, 64'd1);
    @(negedge clk);
    check({tag, "_done_single"}, {63'd0, done_o}, 64'd0);
  endtask

  task automatic start_conv(input string tag, input logic [WIDTH-1:0] v);
    @(negedge clk);
    bin = v; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    measure(tag, v, -1, '0, -1);
  endtask

  // Watch n cycles and report whether busy or done ever rose.
  task automatic idle_watch(input string tag, input int n);
    bit quiet;
    quiet = 1'b1;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (busy_o !== 1'b0 || done_o !== 1'b0) quiet = 1'b0;
    end
    check({tag, "_quiet"}, {63'd0, quiet}, 64'd1);
  endtask

  initial begin
    int n;
    logic [WIDTH-1:0] v;

    rst_n = 1'b0; start = 1'b0; auto_en = 1'b1; bin = '0;

    // Reset state, before any clock edge.
    #1;
    check("rst_bcd",   64'(bcd_o), 64'd0);
    check("rst_busy",  {63'd0, busy_o},  64'd0);
    check("rst_done",  {63'd0, done_o},  64'd0);
    check("rst_valid", {63'd0, valid_o}, 64'd0);

    // Auto mode with bin=0 after reset: last_bin is 0, nothing launches.
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    idle_watch("auto_zero", 10);
    auto_en = 1'b0;

    // Basic conversions, including the extremes.
    start_conv("c12345", 32'd12345);
    check("c12345_exact", 64'(bcd_o), 64'h0000012345);
    start_conv("cmax", 32'hFFFF_FFFF);
    check("cmax_exact", 64'(bcd_o), 64'h4294967295);
    start_conv("czero", 32'd0);

    // Start held high and bin changed while busy: ignored.
    @(negedge clk);
    bin = 32'd100; start = 1'b1;
    @(negedge clk);
    bin = 32'd999;
    measure("ignore", 32'd100, -1, '0, 10);
    check("ignore_exact", 64'(bcd_o), 64'h0000000100);
    check("ignore_no_relaunch", {63'd0, busy_o}, 64'd0);

    // Auto mode: 7 -> 8 -> 8 gives exactly two conversions.
    @(negedge clk);
    auto_en = 1'b1; bin = 32'd7;
    @(negedge clk);
    measure("auto7", 32'd7, -1, '0, -1);
    bin = 32'd8;
    @(negedge clk);
    measure("auto8", 32'd8, -1, '0, -1);
    idle_watch("auto_same", 40);

    // Auto mode: change during CONV is picked up after returning to IDLE.
    bin = 32'd11;
    @(negedge clk);
    measure("auto_mid", 32'd11, 5, 32'd22, -1);
    check("auto_mid_relaunch", {63'd0, busy_o}, 64'd1);
    measure("auto_mid2", 32'd22, -1, '0, -1);
    auto_en = 1'b0;

    // Start held continuously: back-to-back conversions WIDTH+1 cycles apart.
    bin = 32'd55; start = 1'b1;
    n = 0;
    while (done_o !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    check("b2b_first_done", {63'd0, done_o}, 64'd1);
    n = 0;
    do begin @(negedge clk); n++; end while (done_o !== 1'b1 && n < 100);
    check("b2b_spacing", 64'(n), 64'(WIDTH + 1));
    check("b2b_bcd", 64'(bcd_o), 64'h55);
    start = 1'b0;
    @(negedge clk);
    check("b2b_stop", {63'd0, busy_o}, 64'd0);

    // Start and auto-trigger together: a single conversion.
    auto_en = 1'b1; start = 1'b1; bin = 32'd321;
    @(negedge clk);
    start = 1'b0;
    measure("both", 32'd321, -1, '0, -1);
    check("both_single", {63'd0, busy_o}, 64'd0);
    auto_en = 1'b0;

    // Reset mid-conversion: outputs clear asynchronously, no done follows.
    @(negedge clk);
    bin = 32'd12345; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (14) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_bcd",   64'(bcd_o), 64'd0);
    check("arst_busy",  {63'd0, busy_o},  64'd0);
    check("arst_done",  {63'd0, done_o},  64'd0);
    check("arst_valid", {63'd0, valid_o}, 64'd0);
    bin = 32'd0; auto_en = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    idle_watch("arst_after", 40);

    // Auto mode with nonzero bin out of reset launches on the first edge.
    #2 rst_n = 1'b0;
    bin = 32'd5;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_auto_launch", {63'd0, busy_o}, 64'd1);
    measure("rst_auto", 32'd5, -1, '0, -1);
    auto_en = 1'b0;

    // Random regression.
    for (int i = 0; i < c_NRAND; i++) begin
      case (i % 8)
        0:       v = 32'($urandom_range(0, 99));
        1:       v = 32'hFFFF_FFFF - 32'($urandom_range(0, 15));
        2:       v = 32'($urandom_range(0, 99999));
        default: v = $urandom;
      endcase
      start_conv("rand", v);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global watchdog so the bench can never hang.
  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
